// File: rtl/ps2_char_detect.sv
// PS/2 set-2 keyboard receiver that reports one watched make code as a level.
// It also reports the last good byte, with valid and error pulses.
module ps2_char_detect #(
  parameter logic [7:0]  TARGET_CODE = 8'h1C,
  parameter int unsigned TIMEOUT     = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       char_hit,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int unsigned     TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          dat_s1_q, dat_s2_q;
  logic          fall;
  logic          frame_ok;

  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          break_q, break_d;
  logic          ext_q, ext_d;
  logic          hit_q, hit_d;
  logic [7:0]    scan_q, scan_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  // Synchronizers reset to the bus idle level so release never fakes an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall     = clk_prev_q & ~clk_s2_q;
  assign frame_ok = dat_s2_q & (^{shift_q, parity_q});

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    break_d   = break_q;
    ext_d     = ext_q;
    hit_d     = hit_q;
    scan_d    = scan_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (state_q == ST_IDLE || fall) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall && !dat_s2_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (fall) begin
          parity_d = dat_s2_q;
          state_d  = ST_STOP;
        end
      end
      default: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (frame_ok) begin
            valid_d = 1'b1;
            scan_d  = shift_q;
            if (shift_q == BREAK_CODE) begin
              break_d = 1'b1;
            end else if (shift_q == EXT_CODE) begin
              ext_d = 1'b1;
            end else begin
              // Prefix flags are consumed by the first non-prefix byte
              if (!ext_q && shift_q == TARGET_CODE) begin
                hit_d = ~break_q;
              end
              break_d = 1'b0;
              ext_d   = 1'b0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase

    // A fall in the same cycle restarts the window, so it outranks the timeout
    if (state_q != ST_IDLE && !fall && timer_q == T_LAST) begin
      state_d = ST_IDLE;
      timer_d = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      timer_q   <= '0;
      break_q   <= 1'b0;
      ext_q     <= 1'b0;
      hit_q     <= 1'b0;
      scan_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      timer_q   <= timer_d;
      break_q   <= break_d;
      ext_q     <= ext_d;
      hit_q     <= hit_d;
      scan_q    <= scan_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign char_hit   = hit_q;
  assign scan_code  = scan_q;
  assign code_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_char_detect.sv
// Bench for ps2_char_detect: directed frames plus random PS/2 traffic,
// checked every cycle against a bit-list reference model.
module tb_ps2_char_detect;

  localparam int unsigned TMO = 200;
  localparam logic [7:0]  TGT = 8'h1C;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       char_hit;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_char_detect #(.TARGET_CODE(TGT), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .char_hit   (char_hit),
    .scan_code  (scan_code),
    .code_valid (code_valid),
    .frame_err  (frame_err)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cv_cnt = 0;
  int unsigned fe_cnt = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: raw line history, bits collected per frame, idle-cycle count
  bit         m_hit, m_cv, m_fe, m_brk, m_ext, m_in;
  logic [7:0] m_scan;
  int         m_idle;
  bit         m_bits[$];
  bit         hc0 = 1, hc1 = 1, hc2 = 1, hd0 = 1, hd1 = 1;

  function void finish_frame();
    logic [7:0] b;
    int ones;
    b = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      b[i] = m_bits[i];
      ones += int'(m_bits[i]);
    end
    ones += int'(m_bits[8]);
    if ((ones % 2) == 1 && m_bits[9]) begin
      m_cv = 1;
      m_scan = b;
      if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else begin
        if (!m_ext && b == TGT) m_hit = !m_brk;
        m_brk = 0;
        m_ext = 0;
      end
    end else begin
      m_fe = 1;
    end
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_hit = 0; m_cv = 0; m_fe = 0; m_brk = 0; m_ext = 0; m_in = 0;
      m_scan = 8'h00; m_idle = 0; m_bits.delete();
      hc0 = 1; hc1 = 1; hc2 = 1; hd0 = 1; hd1 = 1;
    end else begin : step
      bit f, d;
      f = hc2 && !hc1;
      d = hd1;
      m_cv = 0;
      m_fe = 0;
      if (m_in) begin
        if (f) begin
          m_idle = 0;
          m_bits.push_back(d);
          if (m_bits.size() == 10) begin
            m_in = 0;
            finish_frame();
          end
        end else begin
          m_idle++;
          if (m_idle >= int'(TMO)) begin
            m_in = 0;
            m_fe = 1;
          end
        end
      end else if (f && !d) begin
        m_in = 1;
        m_bits.delete();
        m_idle = 0;
      end
      hc2 = hc1; hc1 = hc0; hc0 = ps2_clk;
      hd1 = hd0; hd0 = ps2_dat;
    end
  end

  always @(negedge clk) begin
    check("char_hit", 32'(char_hit), 32'(m_hit));
    check("scan_code", 32'(scan_code), 32'(m_scan));
    check("code_valid", 32'(code_valid), 32'(m_cv));
    check("frame_err", 32'(frame_err), 32'(m_fe));
    if (code_valid) cv_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit perr, input bit serr);
    logic par;
    par = (~^b) ^ perr;
    return {~serr, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int nbits);
    int hp;
    for (int i = 0; i < nbits; i++) begin
      hp = int'($urandom_range(2, 6));
      ps2_dat = fr[i];
      wait_cyc(hp);
      ps2_clk = 1'b0;
      wait_cyc(hp);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit perr, input bit serr);
    send_bits(mk(b, perr, serr), 11);
    ps2_dat = 1'b1;
    wait_cyc(4);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(2);
  endtask

  int unsigned cv0, fe0;

  initial begin
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(2);
    check("rst_hit", 32'(char_hit), 0);
    check("rst_scan", 32'(scan_code), 0);
    check("rst_cv", 32'(code_valid), 0);
    check("rst_fe", 32'(frame_err), 0);

    cv0 = cv_cnt; fe0 = fe_cnt;
    send(8'h1C, 0, 0);
    check("a_hit", 32'(char_hit), 1);
    check("a_scan", 32'(scan_code), 32'h1C);
    check("a_cv_cnt", cv_cnt - cv0, 1);
    check("a_fe_cnt", fe_cnt - fe0, 0);
    check("model_a_hit", 32'(m_hit), 1);

    cv0 = cv_cnt;
    send(8'hF0, 0, 0);
    check("brk_hit_held", 32'(char_hit), 1);
    send(8'h1C, 0, 0);
    check("brk_hit_clr", 32'(char_hit), 0);
    check("brk_cv_cnt", cv_cnt - cv0, 2);

    cv0 = cv_cnt; fe0 = fe_cnt;
    send(8'h1C, 1, 0);
    check("par_fe_cnt", fe_cnt - fe0, 1);
    check("par_cv_cnt", cv_cnt - cv0, 0);
    check("par_hit", 32'(char_hit), 0);
    check("par_scan", 32'(scan_code), 32'h1C);

    send(8'hE0, 0, 0);
    send(8'h1C, 0, 0);
    check("ext_hit", 32'(char_hit), 0);
    check("ext_scan", 32'(scan_code), 32'h1C);
    send(8'h1C, 0, 0);
    check("ext_then_hit", 32'(char_hit), 1);
    check("model_ext_hit", 32'(m_hit), 1);

    send(8'h32, 0, 0);
    fe0 = fe_cnt;
    send_bits(mk(8'h1C, 0, 0), 5);
    wait_cyc(TMO + 10);
    check("tmo_fe_cnt", fe_cnt - fe0, 1);
    check("model_tmo_idle", 32'(m_in), 0);
    cv0 = cv_cnt; fe0 = fe_cnt;
    send(8'h1C, 0, 0);
    check("tmo_next_cv", cv_cnt - cv0, 1);
    check("tmo_next_fe", fe_cnt - fe0, 0);
    check("tmo_next_scan", 32'(scan_code), 32'h1C);

    send_bits(mk(8'hAA, 0, 0), 6);
    do_reset();
    check("mrst_hit", 32'(char_hit), 0);
    check("mrst_scan", 32'(scan_code), 0);
    send(8'h32, 0, 0);
    check("mrst_scan32", 32'(scan_code), 32'h32);
    check("mrst_hit32", 32'(char_hit), 0);

    for (int it = 0; it < 200; it++) begin
      int r, sel;
      logic [7:0] b;
      logic [10:0] fr;
      r = int'($urandom_range(0, 99));
      sel = int'($urandom_range(0, 99));
      if (sel < 30) b = 8'h1C;
      else if (sel < 45) b = 8'hF0;
      else if (sel < 55) b = 8'hE0;
      else b = 8'($urandom);
      if (r < 8) begin
        send_bits(mk(b, 0, 0), int'($urandom_range(1, 10)));
        wait_cyc(int'(TMO) + int'($urandom_range(0, 20)));
      end else if (r < 13) begin
        send_bits(mk(b, 0, 0), int'($urandom_range(1, 10)));
        do_reset();
      end else if (r < 16) begin
        fr = mk(b, 0, 0);
        fr[0] = 1'b1;
        send_bits(fr, 11);
        wait_cyc(int'(TMO) + 5);
      end else begin
        send(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
      end
      ps2_dat = 1'b1;
      wait_cyc(int'($urandom_range(0, 10)));
    end

    wait_cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
